// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sram-like memory port between the fetch (I)
// and data (D) requesters. Data wins when both ask; a requester that has been
// presented stays locked until its address handshake completes. Accepted
// transactions record their owner in an in-order ID FIFO so each in-order
// response is steered back to the requester that issued it.
module mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   // fetch requester
   input  logic                                 inst_req,
   input  logic                                 inst_wr,
   input  logic [1:0]                           inst_size,
   input  logic [3:0]                           inst_wstrb,
   input  logic [31:0]                          inst_addr,
   input  logic [31:0]                          inst_wdata,
   output logic                                 inst_addr_ok,
   output logic                                 inst_data_ok,
   output logic [31:0]                          inst_rdata,
   // data requester
   input  logic                                 data_req,
   input  logic                                 data_wr,
   input  logic [1:0]                           data_size,
   input  logic [3:0]                           data_wstrb,
   input  logic [31:0]                          data_addr,
   input  logic [31:0]                          data_wdata,
   output logic                                 data_addr_ok,
   output logic                                 data_data_ok,
   output logic [31:0]                          data_rdata,
   // downstream port
   output logic                                 mem_req,
   output logic                                 mem_wr,
   output logic [1:0]                           mem_size,
   output logic [3:0]                           mem_wstrb,
   output logic [31:0]                          mem_addr,
   output logic [31:0]                          mem_wdata,
   input  logic                                 mem_addr_ok,
   input  logic                                 mem_data_ok,
   input  logic [31:0]                          mem_rdata,
   // status
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
   output logic                                 err_spurious
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

   typedef enum logic [1:0] {S_IDLE, S_HOLD_I, S_HOLD_D} state_t;

   state_t                     r_state;
   logic [MAX_OUTSTANDING-1:0] r_fifo;     // owner IDs: 0 = I, 1 = D
   logic [PTR_W-1:0]           r_wr_ptr;
   logic [PTR_W-1:0]           r_rd_ptr;
   logic [CNT_W-1:0]           r_cnt;
   logic                       r_err;

   logic w_sel_i;
   logic w_sel_d;
   logic w_sel_req;
   logic w_full;
   logic w_empty;
   logic w_accept;
   logic w_pop;
   logic w_head;

   // Selection: a locked owner keeps the port; otherwise data beats fetch.
   always_comb begin
      w_sel_i = 1'b0;
      w_sel_d = 1'b0;
      case (r_state)
         S_HOLD_I: w_sel_i = 1'b1;
         S_HOLD_D: w_sel_d = 1'b1;
         default: begin
            w_sel_d = data_req;
            w_sel_i = ~data_req & inst_req;
         end
      endcase
   end

   assign w_full    = (r_cnt == CNT_W'(MAX_OUTSTANDING));
   assign w_empty   = (r_cnt == '0);
   // A locked owner that drops req presents nothing until it reasserts.
   assign w_sel_req = (w_sel_i & inst_req) | (w_sel_d & data_req);
   assign mem_req   = w_sel_req & ~w_full;
   assign w_accept  = mem_req & mem_addr_ok;

   // Request field mux; fields are zero when nobody is selected.
   always_comb begin
      mem_wr    = 1'b0;
      mem_size  = 2'd0;
      mem_wstrb = 4'd0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      if (w_sel_d) begin
         mem_wr    = data_wr;
         mem_size  = data_size;
         mem_wstrb = data_wstrb;
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
      end else if (w_sel_i) begin
         mem_wr    = inst_wr;
         mem_size  = inst_size;
         mem_wstrb = inst_wstrb;
         mem_addr  = inst_addr;
         mem_wdata = inst_wdata;
      end
   end

   assign inst_addr_ok = w_accept & w_sel_i;
   assign data_addr_ok = w_accept & w_sel_d;

   // Responses return in order; the FIFO head names the requester.
   assign w_pop        = mem_data_ok & ~w_empty;
   assign w_head       = r_fifo[r_rd_ptr];
   assign inst_data_ok = w_pop & ~w_head;
   assign data_data_ok = w_pop & w_head;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   assign outstanding_cnt = r_cnt;
   assign err_spurious    = r_err;

   // Ownership: lock whatever was selected unless its handshake completed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)       r_state <= S_IDLE;
      else if (w_accept) r_state <= S_IDLE;
      else if (w_sel_d)  r_state <= S_HOLD_D;
      else if (w_sel_i)  r_state <= S_HOLD_I;
      else               r_state <= S_IDLE;
   end

   // Owner-ID FIFO; count is kept apart from the pointers to tell full from empty.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fifo   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_accept) begin
            r_fifo[r_wr_ptr] <= w_sel_d;
            r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_accept, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Sticky flag for a response that nobody is waiting for.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                     r_err <= 1'b0;
      else if (mem_data_ok && w_empty) r_err <= 1'b1;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based reference model of the arbiter.
module tb_mem_port_arbiter;

   localparam int MAX = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [2:0]  outstanding_cnt;
   logic        err_spurious;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int q[$];       // owner IDs of accepted, unreturned transactions
   int lock = -1;  // -1 none, 0 fetch, 1 data
   bit m_err = 0;
   bit i_pend = 0, d_pend = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .outstanding_cnt(outstanding_cnt), .err_spurious(err_spurious)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   task automatic model_reset();
      q.delete(); lock = -1; m_err = 0; i_pend = 0; d_pend = 0;
   endtask

   // Check all outputs for the current inputs, then advance model across posedge.
   task automatic cycle();
      int sel;
      logic sreq, full, e_req, acc, pop, head_d;
      logic [38:0] e_ctl;
      logic [31:0] e_addr, e_wdata;
      #1;
      if (lock >= 0)     sel = lock;
      else if (data_req) sel = 1;
      else if (inst_req) sel = 0;
      else               sel = -1;
      sreq   = (sel == 1) ? data_req : (sel == 0) ? inst_req : 1'b0;
      full   = (q.size() == MAX);
      e_req  = sreq && !full;
      acc    = e_req && mem_addr_ok;
      pop    = mem_data_ok && (q.size() > 0);
      head_d = pop ? (q[0] == 1) : 1'b0;
      if (sel == 1) begin
         e_ctl = {32'd0, data_wr, data_size, data_wstrb}; e_addr = data_addr; e_wdata = data_wdata;
      end else if (sel == 0) begin
         e_ctl = {32'd0, inst_wr, inst_size, inst_wstrb}; e_addr = inst_addr; e_wdata = inst_wdata;
      end else begin
         e_ctl = '0; e_addr = '0; e_wdata = '0;
      end
      chk("mem_req", mem_req, e_req);
      chk("mem_ctl", {32'd0, mem_wr, mem_size, mem_wstrb}, e_ctl);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("inst_addr_ok", inst_addr_ok, acc && sel == 0);
      chk("data_addr_ok", data_addr_ok, acc && sel == 1);
      chk("inst_data_ok", inst_data_ok, pop && !head_d);
      chk("data_data_ok", data_data_ok, pop && head_d);
      if (pop) begin
         chk("inst_rdata", inst_rdata, mem_rdata);
         chk("data_rdata", data_rdata, mem_rdata);
      end
      chk("cnt", outstanding_cnt, q.size());
      chk("err", err_spurious, m_err);
      @(posedge clk);
      if (mem_data_ok && q.size() == 0) m_err = 1;
      if (pop) void'(q.pop_front());
      if (acc) begin
         q.push_back(sel);
         lock = -1;
      end else if (sel >= 0) lock = sel;
      i_pend = inst_req && !(acc && sel == 0);
      d_pend = data_req && !(acc && sel == 1);
      @(negedge clk);
   endtask

   task automatic drain();
      mem_data_ok = 1;
      for (int k = 0; k < 20 && q.size() > 0; k++) begin
         mem_rdata = $urandom;
         cycle();
      end
      mem_data_ok = 0;
      chk("drain_empty", outstanding_cnt, 0);
   endtask

   // Random requesters mostly follow the hold-until-accept rule, with rare illegal drops.
   task automatic drive_rand();
      if (!i_pend || $urandom_range(0, 19) == 0) begin
         inst_req   = ($urandom_range(0, 1) == 1);
         inst_wr    = ($urandom_range(0, 7) == 0);
         inst_size  = 2'($urandom_range(0, 2));
         inst_wstrb = 4'($urandom);
         inst_addr  = $urandom;
         inst_wdata = $urandom;
      end
      if (!d_pend || $urandom_range(0, 19) == 0) begin
         data_req   = ($urandom_range(0, 2) == 0);
         data_wr    = ($urandom_range(0, 1) == 1);
         data_size  = 2'($urandom_range(0, 2));
         data_wstrb = 4'($urandom);
         data_addr  = $urandom;
         data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_rdata   = $urandom;
   endtask

   initial begin
      clear_inputs();
      model_reset();
      resetn = 0;
      #12;
      chk("rst_cnt", outstanding_cnt, 0);
      chk("rst_err", err_spurious, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
      @(negedge clk);
      resetn = 1;

      // single fetch
      inst_req = 1; inst_size = 2; inst_addr = 32'h1c000000; mem_addr_ok = 1;
      #1 chk("fetch_addr_ok", inst_addr_ok, 1);
      cycle();
      inst_req = 0; mem_addr_ok = 0;
      cycle(); cycle();
      chk("fetch_cnt1", outstanding_cnt, 1);
      mem_data_ok = 1; mem_rdata = 32'h02800000;
      #1 chk("fetch_rdata", {inst_data_ok, inst_rdata}, {1'b1, 32'h02800000});
      cycle();
      mem_data_ok = 0;
      cycle();
      chk("fetch_cnt0", outstanding_cnt, 0);

      // contention: data wins, fetch follows
      inst_req = 1; inst_addr = 32'h1c000004;
      data_req = 1; data_addr = 32'h80; data_wr = 1; data_wstrb = 4'hF; data_size = 2;
      mem_addr_ok = 1;
      #1 chk("cont_addr", {mem_wr, mem_addr, data_addr_ok, inst_addr_ok}, {1'b1, 32'h80, 2'b10});
      cycle();
      data_req = 0;
      cycle();
      inst_req = 0;
      drain();

      // lock: stalled fetch keeps the port when data arrives
      inst_req = 1; inst_addr = 32'h1c000100; mem_addr_ok = 0;
      cycle(); cycle();
      data_req = 1; data_addr = 32'h200;
      cycle();
      mem_addr_ok = 1;
      #1 chk("lock_addr", mem_addr, 32'h1c000100);
      cycle();
      inst_req = 0;
      cycle();
      data_req = 0;
      drain();

      // full: four accepts, then a pop re-opens the port one cycle later
      inst_req = 1; mem_addr_ok = 1;
      repeat (4) cycle();
      #1 chk("full_cnt", {outstanding_cnt, mem_req}, {3'd4, 1'b0});
      cycle();
      mem_data_ok = 1;
      cycle();
      mem_data_ok = 0;
      #1 chk("full_reopen", mem_req, 1);
      cycle();
      inst_req = 0; mem_addr_ok = 0;
      drain();

      // randomized traffic
      repeat (2000) begin
         drive_rand();
         cycle();
      end
      clear_inputs();
      cycle(); cycle();
      drain();

      // spurious response
      mem_data_ok = 1;
      cycle();
      mem_data_ok = 0;
      cycle(); cycle();
      chk("spurious_err", err_spurious, 1);

      // reset with two outstanding
      inst_req = 1; mem_addr_ok = 1;
      cycle(); cycle();
      clear_inputs();
      #2 resetn = 0;
      model_reset();
      #1 chk("midrst", {outstanding_cnt, err_spurious}, 0);
      @(negedge clk);
      resetn = 1;
      mem_data_ok = 1;
      cycle();
      mem_data_ok = 0;
      cycle();
      chk("post_rst_spurious", {err_spurious, inst_data_ok, data_data_ok}, 3'b100);

      repeat (500) begin
         drive_rand();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single sram-like memory port between the instruction-fetch requester (port I) and the MEM-stage data requester (port D).
- Sits between the IF/EXE request generators and the AXI bridge.
- Fixes request ownership until the address handshake completes, and tracks outstanding transactions in an in-order ID FIFO so that each data_ok/rdata goes back to the right requester.
- Data requests take priority over fetch.

Parameters:
- MAX_OUTSTANDING, 4, depth of the owner-ID FIFO (power of two, ≥2); maximum accepted-but-unreturned transactions.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request
- inst_wr  in  1  write flag (normally 0)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_wstrb  in  4  byte strobes
- inst_addr  in  32  address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  32  fetch read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data-port request, same meaning as inst_*
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- mem_req  out  1  downstream request
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  muxed request fields
- mem_addr_ok  in  1  downstream accept
- mem_data_ok  in  1  downstream response, in order
- mem_rdata  in  32  downstream read data
- outstanding_cnt  out  3  accepted, unreturned transactions (0..MAX_OUTSTANDING)
- err_spurious  out  1  sticky: mem_data_ok seen with FIFO empty

Behaviour:
- Reset:
  - Asynchronous on resetn=0: state=IDLE, FIFO pointers=0, count=0, err_spurious=0.
  - All handshake outputs are low while no requester is asserting.
  - The rdata outputs pass mem_rdata through and are don't-care unless their data_ok is high.
- States:
  - IDLE: no locked owner. Candidate = D if data_req, else I if inst_req, else none.
  - HOLD_I / HOLD_D: the locked owner's fields drive mem_*; the other requester is ignored.
- Request presentation:
  - mem_req = candidate-or-owner req & ~full. full means count==MAX_OUTSTANDING.
  - mem_* fields come from the selected requester; zero when none is selected.
- Address handshake:
  - The selected requester's addr_ok = mem_addr_ok & mem_req. The other requester's addr_ok is 0.
  - On that accept: push the owner ID (0=I, 1=D) into the FIFO, go to IDLE.
- Transitions:
  - IDLE with mem_req=1 and mem_addr_ok=0 → HOLD_<owner>. The owner stays locked even if the other side's req rises.
  - IDLE with full and a candidate present → HOLD_<candidate>. The candidate is locked without presenting (mem_req=0).
  - HOLD_x with accept → IDLE.
  - HOLD_x with the owner's req dropping is illegal (sram-like rule). The arbiter stays in HOLD_x and presents mem_req=0 until req reasserts.
- Response path:
  - mem_data_ok & FIFO non-empty: pop the head. Head=0 → inst_data_ok=1; head=1 → data_data_ok=1.
  - Both requesters receive mem_rdata combinationally, same cycle, zero latency.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- A pop allowed while full frees the slot for the next cycle only. mem_req is not re-enabled combinationally by the same-cycle pop.
- Pointer wrap: pointers are log2(MAX_OUTSTANDING) bits and wrap naturally. count is kept separately to distinguish full from empty.
- Spurious mem_data_ok with FIFO empty:
  - No data_ok is forwarded and the pointers are unchanged.
  - err_spurious is set and held until reset.
- Latency: request path is combinational, 0 cycles; response path is 0 cycles; ownership update is 1 cycle.
- Reset mid-transaction: all FIFO contents are discarded. Later mem_data_ok responses are treated as spurious.

Test Plan:
- Single fetch: inst_req=1, addr 0x1c000000, mem_addr_ok=1 → inst_addr_ok=1 same cycle. 3 cycles later mem_data_ok=1, rdata 0x02800000 → inst_data_ok=1 with inst_rdata=0x02800000; count 1→0.
- Contention: inst_req and data_req high together (data_addr 0x80, wr=1, wstrb=0xF) → mem_addr=0x80, mem_wr=1, data_addr_ok=1, inst_addr_ok=0. Next cycle the fetch is granted.
- Lock: inst_req alone, mem_addr_ok=0 for 2 cycles, then data_req rises → mem_addr stays the inst address until accept. The data request follows on the next cycle.
- Ordering: accept I, D, I, D back-to-back, then four mem_data_ok pulses → data_ok pulses go to inst, data, inst, data in that order.
- Full: MAX_OUTSTANDING=4 accepts, no responses → count=4 and mem_req=0 with inst_req high. One mem_data_ok → next cycle mem_req=1.
- Error/reset: mem_data_ok with count=0 → no data_ok, err_spurious=1 and held. Async resetn pulse mid-stream with 2 outstanding → count=0, err cleared.
